// File: rtl/pll_lock_monitor.sv
// -----------------------------------------------------------------------------
// pll_lock_monitor
//
// Watches an asynchronous PLL lock flag and, once lock has been seen
// continuously for STABLE_CYCLES reference-clock cycles, releases an active-high
// reset for the downstream (pixel / TMDS) domains. An optional heartbeat
// frequency check counts heartbeat toggles per WINDOW cycles and flags a
// generated clock that runs at the wrong rate.
//
// Optional feature macro: FREQ_CHECK_EN
//   defined   : heartbeat synchronizer, window and edge counters are built; a
//               bad window while running forces HOLD and sets fault.
//   undefined : heartbeat is ignored; hb_count = 0, hb_valid = 0, hb_ok = 1.
//
// Ports
//   clock        in   reference/monitor clock (single clock domain)
//   reset        in   synchronous, active-high reset
//   locked_in    in   PLL lock flag, asynchronous
//   heartbeat    in   toggle from the monitored domain, asynchronous
//   clear_fault  in   synchronous pulse, clears fault
//   rst_out      out  active-high reset for downstream domains
//   ready        out  inverse of rst_out
//   hb_count     out  heartbeat edge count of the last completed window
//   hb_valid     out  one-cycle pulse when hb_count updates
//   hb_ok        out  last completed window count within [HB_MIN, HB_MAX]
//   fault        out  sticky: lock lost or frequency bad while running
// -----------------------------------------------------------------------------
module pll_lock_monitor #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned WINDOW        = 4096,
  parameter int unsigned HB_MIN        = 800,
  parameter int unsigned HB_MAX        = 840,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        locked_in,
  input  logic        heartbeat,
  input  logic        clear_fault,
  output logic        rst_out,
  output logic        ready,
  output logic [15:0] hb_count,
  output logic        hb_valid,
  output logic        hb_ok,
  output logic        fault
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic                   fault_q, fault_d;
  logic                   fault_set_s;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   locked_s;
  logic                   bad_window_s;

  // Lock flag synchronizer chain; newest sample enters at bit 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign locked_s = lock_sync_q[SYNC_STAGES-1];

`ifdef FREQ_CHECK_EN
  localparam int unsigned WIN_W = $clog2(WINDOW);

  logic [SYNC_STAGES-1:0] hb_sync_q;
  logic                   hb_dly_q;
  logic                   hb_s;
  logic                   hb_edge_s;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [15:0]            edge_q, edge_d;
  logic [15:0]            edge_sum_s;
  logic [15:0]            hb_count_q, hb_count_d;
  logic                   hb_valid_q, hb_valid_d;
  logic                   hb_ok_q, hb_ok_d;
  logic                   wrap_s;
  logic                   in_range_s;

  assign hb_s      = hb_sync_q[SYNC_STAGES-1];
  // Both heartbeat edges count, so any change of the synchronized level is one edge.
  assign hb_edge_s = hb_s ^ hb_dly_q;

  // Heartbeat synchronizer, edge-detect flop and window bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      hb_sync_q  <= '0;
      hb_dly_q   <= 1'b0;
      win_q      <= '0;
      edge_q     <= 16'd0;
      hb_count_q <= 16'd0;
      hb_valid_q <= 1'b0;
      hb_ok_q    <= 1'b0;
    end else begin
      hb_sync_q  <= {hb_sync_q[SYNC_STAGES-2:0], heartbeat};
      hb_dly_q   <= hb_s;
      win_q      <= win_d;
      edge_q     <= edge_d;
      hb_count_q <= hb_count_d;
      hb_valid_q <= hb_valid_d;
      hb_ok_q    <= hb_ok_d;
    end
  end

  // Window counter wrap, saturating edge accumulation and window result capture.
  always_comb begin
    win_d        = win_q;
    edge_d       = edge_q;
    hb_count_d   = hb_count_q;
    hb_valid_d   = 1'b0;
    hb_ok_d      = hb_ok_q;
    bad_window_s = 1'b0;

    // The edge seen on the wrap cycle still belongs to the closing window.
    if (edge_q == 16'hFFFF) begin
      edge_sum_s = edge_q;
    end else begin
      edge_sum_s = edge_q + {15'd0, hb_edge_s};
    end

    wrap_s     = (win_q == WIN_W'(WINDOW - 1));
    in_range_s = (edge_sum_s >= 16'(HB_MIN)) && (edge_sum_s <= 16'(HB_MAX));

    if (wrap_s) begin
      win_d        = '0;
      edge_d       = 16'd0;
      hb_count_d   = edge_sum_s;
      hb_valid_d   = 1'b1;
      hb_ok_d      = in_range_s;
      bad_window_s = ~in_range_s;
    end else begin
      win_d  = win_q + WIN_W'(1);
      edge_d = edge_sum_s;
    end
  end

  assign hb_count = hb_count_q;
  assign hb_valid = hb_valid_q;
  assign hb_ok    = hb_ok_q;
`else
  logic unused_s;

  // Heartbeat and window parameters have no function without the frequency check.
  assign unused_s     = heartbeat ^ (^(WINDOW + HB_MIN + HB_MAX));
  assign bad_window_s = 1'b0;
  assign hb_count     = 16'd0;
  assign hb_valid     = 1'b0;
  assign hb_ok        = 1'b1;
`endif

  // State, qualification counter and sticky fault registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_HOLD;
      stab_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      fault_q <= fault_d;
    end
  end

  // Lock qualification next-state logic and fault set/clear arbitration.
  always_comb begin
    state_d     = state_q;
    stab_d      = stab_q;
    fault_set_s = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (locked_s) begin
          state_d = ST_WAIT;
          stab_d  = '0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_WAIT: begin
        // Any low sample restarts qualification from scratch.
        if (!locked_s) begin
          state_d = ST_HOLD;
        end else if (stab_q == STAB_W'(STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s || bad_window_s) begin
          state_d     = ST_HOLD;
          fault_set_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_HOLD;
        stab_d  = '0;
      end
    endcase

    // A new fault in the same cycle as clear_fault must not be lost.
    if (fault_set_s) begin
      fault_d = 1'b1;
    end else if (clear_fault) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  // Decoded straight from the state register so release/assert latency is exact.
  assign rst_out = (state_q != ST_RUN);
  assign ready   = (state_q == ST_RUN);
  assign fault   = fault_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
`timescale 1ns/1ps
module tb_pll_lock_monitor;

  localparam int STABLE = 16;
  localparam int WIN    = 64;
  localparam int HMIN   = 10;
  localparam int HMAX   = 14;
  localparam int SYNC   = 2;
`ifdef FREQ_CHECK_EN
  localparam bit FREQ = 1'b1;
`else
  localparam bit FREQ = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        locked_in = 1'b0;
  logic        heartbeat = 1'b0;
  logic        clear_fault = 1'b0;
  logic        rst_out;
  logic        ready;
  logic [15:0] hb_count;
  logic        hb_valid;
  logic        hb_ok;
  logic        fault;

  always #5 clock = ~clock;

  pll_lock_monitor #(
    .STABLE_CYCLES(STABLE),
    .WINDOW       (WIN),
    .HB_MIN       (HMIN),
    .HB_MAX       (HMAX),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .locked_in  (locked_in),
    .heartbeat  (heartbeat),
    .clear_fault(clear_fault),
    .rst_out    (rst_out),
    .ready      (ready),
    .hb_count   (hb_count),
    .hb_valid   (hb_valid),
    .hb_ok      (hb_ok),
    .fault      (fault)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hb_period = 0;
  int fail_prints = 0;

  // Reference model: lock qualification as a run-length of high synchronized
  // samples, windows as modular cycle arithmetic since the last reset.
  bit          m_run;
  int          m_qual;
  bit          m_fault;
  logic [15:0] m_hbc;
  bit          m_hbv;
  bit          m_hbok;
  int          m_t;
  int          m_edges;
  bit          lk_hist[$];
  bit          hb_hist[$];

  function automatic void model_reset();
    m_run = 1'b0; m_qual = 0; m_fault = 1'b0;
    m_hbc = 16'd0; m_hbv = 1'b0; m_hbok = !FREQ;
    m_t = 0; m_edges = 0;
    lk_hist.delete(); hb_hist.delete();
    for (int i = 0; i <= SYNC; i++) begin
      lk_hist.push_back(1'b0);
      hb_hist.push_back(1'b0);
    end
  endfunction

  function automatic void model_edge(input bit rst, input bit lk, input bit hb, input bit clr);
    bit lk_used, e, wrap, bad, set;
    int tot;
    if (rst) begin
      model_reset();
      return;
    end
    // hist[i] holds the sample taken i+1 edges ago
    lk_used = lk_hist[SYNC-1];
    e = hb_hist[SYNC-1] ^ hb_hist[SYNC];
    bad = 1'b0;
    m_hbv = 1'b0;
    if (FREQ) begin
      wrap = ((m_t % WIN) == WIN - 1);
      m_t++;
      tot = m_edges + int'(e);
      if (tot > 65535) tot = 65535;
      if (wrap) begin
        m_hbc = 16'(tot);
        m_hbv = 1'b1;
        m_hbok = (tot >= HMIN) && (tot <= HMAX);
        bad = !m_hbok;
        m_edges = 0;
      end else begin
        m_edges = tot;
      end
    end
    set = 1'b0;
    if (m_run) begin
      if (!lk_used || bad) begin
        m_run = 1'b0; m_qual = 0; set = 1'b1;
      end
    end else if (lk_used) begin
      m_qual++;
      if (m_qual > STABLE) m_run = 1'b1;
    end else begin
      m_qual = 0;
    end
    if (set) m_fault = 1'b1;
    else if (clr) m_fault = 1'b0;
    lk_hist.push_front(lk); void'(lk_hist.pop_back());
    hb_hist.push_front(hb); void'(hb_hist.pop_back());
  endfunction

  task automatic note_fail(input string msg);
    n_bad++;
    if (fail_prints < 40) $display("FAIL %s", msg);
    fail_prints++;
  endtask

  task automatic check_model();
    logic [20:0] act, exp;
    act = {rst_out, ready, hb_count, hb_valid, hb_ok, fault};
    exp = {!m_run, m_run, m_hbc, m_hbv, m_hbok, m_fault};
    n_cmp++;
    if (act !== exp)
      note_fail($sformatf("model cyc=%0d got {rst,rdy,cnt,vld,ok,flt}=%h want %h", cyc, act, exp));
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp)
      note_fail($sformatf("%s cyc=%0d got %0h want %0h", name, cyc, act, exp));
  endtask

  // One clock edge: inputs are applied before the edge, outputs checked 1ns after.
  task automatic step(input bit rst, input bit lk, input bit clr);
    if (hb_period != 0 && (cyc % hb_period) == 0) heartbeat = ~heartbeat;
    reset = rst; locked_in = lk; clear_fault = clr;
    @(posedge clock);
    cyc++;
    model_edge(rst, lk, heartbeat, clr);
    #1;
    check_model();
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (hb_valid === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got) note_fail($sformatf("wait_hb_valid cyc=%0d got no pulse want pulse within 200 cycles", cyc));
  endtask

  typedef struct {
    int n;
    bit rst;
    bit lk;
    bit clr;
    bit exp_rst;
    bit exp_fault;
    bit zero_hbc;
  } vec_t;

  vec_t vecs[24];
  int   nv = 0;

  function automatic void add(input int n, input bit rst, input bit lk, input bit clr,
                              input bit er, input bit ef, input bit zh);
    vecs[nv] = '{n, rst, lk, clr, er, ef, zh};
    nv++;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int seg;
    bit lk_r, clr_r, rst_r;
    model_reset();

    // Directed sequence; edge numbers in comments are cumulative from edge 1.
    add(4,  1, 0, 0, 1, 0, 1);  // 1-4 reset
    add(5,  0, 0, 0, 1, 0, 0);  // 5-9
    add(18, 0, 1, 0, 1, 0, 0);  // 10-27 locked, still held
    add(1,  0, 1, 0, 0, 0, 0);  // 28 release
    add(6,  0, 1, 0, 0, 0, 0);  // 29-34
    add(2,  0, 0, 0, 0, 0, 0);  // 35-36 lock lost at 35, still running
    add(1,  0, 0, 0, 1, 1, 0);  // 37 reset asserted, fault
    add(1,  0, 0, 1, 1, 0, 0);  // 38 clear_fault, lock still low
    add(2,  0, 0, 0, 1, 0, 0);  // 39-40
    add(4,  1, 0, 0, 1, 0, 1);  // 41-44 reset
    add(5,  0, 0, 0, 1, 0, 0);  // 45-49
    add(10, 0, 1, 0, 1, 0, 0);  // 50-59 locked
    add(1,  0, 0, 0, 1, 0, 0);  // 60 one-cycle glitch
    add(8,  0, 1, 0, 1, 0, 0);  // 61-68 unglitched release point passes
    add(10, 0, 1, 0, 1, 0, 0);  // 69-78
    add(1,  0, 1, 0, 0, 0, 0);  // 79 release = 61 + 18
    add(5,  0, 1, 0, 0, 0, 0);  // 80-84
    add(2,  0, 0, 0, 0, 0, 0);  // 85-86 lock lost at 85
    add(1,  0, 0, 1, 1, 1, 0);  // 87 clear on the fault edge: fault wins
    add(18, 0, 1, 0, 1, 1, 0);  // 88-105
    add(1,  0, 1, 0, 0, 1, 0);  // 106 release
    add(5,  0, 1, 0, 0, 1, 0);  // 107-111
    add(1,  1, 1, 0, 1, 0, 1);  // 112 reset while running

    hb_period = 5;
    for (int i = 0; i < nv; i++) begin
      for (int c = 0; c < vecs[i].n; c++) step(vecs[i].rst, vecs[i].lk, vecs[i].clr);
      chk($sformatf("vec%0d_rst_out", i), 16'(rst_out), 16'(vecs[i].exp_rst));
      chk($sformatf("vec%0d_ready", i), 16'(ready), 16'(!vecs[i].exp_rst));
      chk($sformatf("vec%0d_fault", i), 16'(fault), 16'(vecs[i].exp_fault));
      if (vecs[i].zero_hbc) chk($sformatf("vec%0d_hb_count", i), hb_count, 16'd0);
    end

    // Frequency sequence: release, in-range windows, then a too-fast heartbeat.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    chk("freq_release_rst_out", 16'(rst_out), 16'd0);
`ifdef FREQ_CHECK_EN
    wait_valid(got);
    for (int w = 0; w < 3; w++) begin
      wait_valid(got);
      chk("p5_count_12_13", 16'(hb_count >= 16'd12 && hb_count <= 16'd13), 16'd1);
      chk("p5_hb_ok", 16'(hb_ok), 16'd1);
      chk("p5_rst_out", 16'(rst_out), 16'd0);
    end
    hb_period = 3;
    wait_valid(got);
    chk("p3_fault", 16'(fault), 16'd1);
    chk("p3_hb_ok", 16'(hb_ok), 16'd0);
    chk("p3_rst_out", 16'(rst_out), 16'd1);
    wait_valid(got);
    chk("p3_count_21_22", 16'(hb_count >= 16'd21 && hb_count <= 16'd22), 16'd1);
`else
    for (int i = 0; i < 150; i++) step(1'b0, 1'b1, 1'b0);
    hb_period = 3;
    for (int i = 0; i < 150; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("nofreq_hb_valid", 16'(hb_valid), 16'd0);
    end
    chk("nofreq_hb_count", hb_count, 16'd0);
    chk("nofreq_hb_ok", 16'(hb_ok), 16'd1);
    chk("nofreq_rst_out", 16'(rst_out), 16'd0);
    chk("nofreq_fault", 16'(fault), 16'd0);
`endif

    // Randomized traffic against the reference model.
    step(1'b1, 1'b0, 1'b0);
    seg = 0;
    lk_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        seg = $urandom_range(1, 80);
        lk_r = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 3) == 0) begin
          hb_period = $urandom_range(2, 6);
          if (hb_period == 2) hb_period = 0;
        end
      end
      seg--;
      if (hb_period == 0 && $urandom_range(0, 3) == 0) heartbeat = ~heartbeat;
      clr_r = ($urandom_range(0, 15) == 0);
      rst_r = ($urandom_range(0, 499) == 0);
      step(rst_r, lk_r, clr_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
